instr_fetch_unit: RTL and testbench

Multicycle instruction fetch stage that sits directly upstream of the control FSM and datapath. It owns the program counter and addresses the 1024-word instruction memory. It latches each fetched word into an instruction register and presents it to the downstream stage with a valid/ready handshake. It also computes the next PC for sequential flow, J/JAL, JR and branch redirects, and supplies the JAL link value (PC+8).

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: owns the PC, reads the instruction
// memory, latches the word, and hands it downstream with a valid/ready
// handshake. Computes the next PC for sequential, J/JAL, JR and branches.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | imem_addr = pc[11:2]; the word is captured on the next edge
// HOLD  | instr valid; waits for instr_ready, then PC takes next_pc
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] link_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_reg,
    input  logic [25:0] redirect_imm,
    output logic        misalign_err,
    output logic [15:0] instr_count
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [1:0] SEL_JR     = 2'd0;
    localparam logic [1:0] SEL_J      = 2'd1;
    localparam logic [1:0] SEL_BRANCH = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [15:0] count_q, count_d;
    logic        misalign_q, misalign_d;

    logic        fetch_en;
    logic        accept;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // State register: reset forces FETCH and drops any pending instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one FETCH cycle, then HOLD until downstream accepts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_HOLD;
            ST_HOLD:  if (instr_ready) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // FSM outputs: valid in HOLD, accept is the handshake completing
    always_comb begin
        fetch_en    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_HOLD);
        accept      = (state_q == ST_HOLD) && instr_ready;
    end

    // Next-PC selection; sel 3 falls through to sequential flow
    always_comb begin
        pc4           = instr_pc_q + 32'd4;
        next_pc       = pc4;
        jr_misaligned = 1'b0;
        if (redirect_valid) begin
            case (redirect_sel)
                SEL_JR: begin
                    next_pc       = {redirect_reg[31:2], 2'b00};
                    jr_misaligned = (redirect_reg[1:0] != 2'b00);
                end
                SEL_J:      next_pc = {pc4[31:28], redirect_imm, 2'b00};
                SEL_BRANCH: next_pc = pc4 + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
                default:    next_pc = pc4;
            endcase
        end
    end

    // Datapath next values: capture on fetch, advance PC and count on accept
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (fetch_en) begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
        end
        if (accept) begin
            pc_d       = next_pc;
            count_d    = count_q + 16'd1;
            misalign_d = misalign_q | jr_misaligned;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            count_q    <= 16'h0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Output drive; fetch addresses wrap within the 4 KB window
    always_comb begin
        imem_addr    = pc_q[11:2];
        instr        = instr_q;
        instr_pc     = instr_pc_q;
        link_addr    = instr_pc_q + 32'd8;
        instr_count  = count_q;
        misalign_err = misalign_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential flow, JAL, JR with
// misalignment, backward branch, stall with ignored redirect, reset mid-HOLD
// and 4 KB fetch-address wrap. Memory word i holds 32'hA000_0000 + i.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] link_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] redirect_reg;
    logic [25:0] redirect_imm;
    logic        misalign_err;
    logic [15:0] instr_count;

    logic [31:0] mem [1024];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .link_addr      (link_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .redirect_reg   (redirect_reg),
        .redirect_imm   (redirect_imm),
        .misalign_err   (misalign_err),
        .instr_count    (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the full HOLD-state view of one instruction
    task automatic hold_chk(input string tag, input logic [31:0] epc,
                            input logic [31:0] einstr, input logic [15:0] ecnt);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_pc"},    instr_pc, epc);
        chk({tag, "_instr"}, instr, einstr);
        chk({tag, "_link"},  link_addr, epc + 32'd8);
        chk({tag, "_count"}, {16'b0, instr_count}, {16'b0, ecnt});
    endtask

    // Called at a negedge in HOLD: accepts with the given redirect, checks the
    // FETCH cycle, and returns at the negedge of the following HOLD cycle
    task automatic accept(input string tag, input logic rv, input logic [1:0] sel,
                          input logic [31:0] rreg, input logic [25:0] imm,
                          input logic [9:0] exp_addr);
        instr_ready    = 1'b1;
        redirect_valid = rv;
        redirect_sel   = sel;
        redirect_reg   = rreg;
        redirect_imm   = imm;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_sel   = 2'd3;
        redirect_imm   = 26'h3FF_FFFF;
        chk({tag, "_fetch_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_fetch_addr"},  {22'b0, imem_addr}, {22'b0, exp_addr});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        reset          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_sel   = 2'd0;
        redirect_reg   = 32'h0;
        redirect_imm   = 26'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("rst_instr",    instr, 32'h0);
        chk("rst_pc",       instr_pc, 32'h0);
        chk("rst_count",    {16'b0, instr_count}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_addr",     {22'b0, imem_addr}, 32'd0);

        // Sequential flow
        reset = 1'b1;
        @(negedge clk);
        hold_chk("seq0", 32'h0000_0000, 32'hA000_0000, 16'd0);
        accept("seq1", 1'b0, 2'd0, 32'h0, 26'h0, 10'd1);
        hold_chk("seq1", 32'h0000_0004, 32'hA000_0001, 16'd1);
        accept("seq2", 1'b0, 2'd0, 32'h0, 26'h0, 10'd2);
        hold_chk("seq2", 32'h0000_0008, 32'hA000_0002, 16'd2);
        accept("seq3", 1'b0, 2'd0, 32'h0, 26'h0, 10'd3);
        hold_chk("seq3", 32'h0000_000C, 32'hA000_0003, 16'd3);
        accept("seq4", 1'b0, 2'd0, 32'h0, 26'h0, 10'd4);
        hold_chk("seq4", 32'h0000_0010, 32'hA000_0004, 16'd4);

        // Forward branch to 0x40: 0x14 + 11*4
        accept("brf", 1'b1, 2'd2, 32'h0, 26'h000_000B, 10'h010);
        hold_chk("brf", 32'h0000_0040, 32'hA000_0010, 16'd5);

        // JAL: link 0x48 checked above, target {0, 0x100, 00} = 0x400
        accept("jal", 1'b1, 2'd1, 32'h0, 26'h000_0100, 10'h100);
        hold_chk("jal", 32'h0000_0400, 32'hA000_0100, 16'd6);
        chk("jal_misalign", {31'b0, misalign_err}, 32'd0);

        // JR to 0x203: target 0x200, misalign flag sets
        accept("jr", 1'b1, 2'd0, 32'h0000_0203, 26'h0, 10'h080);
        hold_chk("jr", 32'h0000_0200, 32'hA000_0080, 16'd7);
        chk("jr_misalign", {31'b0, misalign_err}, 32'd1);
        accept("s5a", 1'b0, 2'd0, 32'h0, 26'h0, 10'h081);
        accept("s5b", 1'b0, 2'd0, 32'h0, 26'h0, 10'h082);
        accept("s5c", 1'b0, 2'd0, 32'h0, 26'h0, 10'h083);
        accept("s5d", 1'b0, 2'd0, 32'h0, 26'h0, 10'h084);
        accept("s5e", 1'b0, 2'd0, 32'h0, 26'h0, 10'h085);
        hold_chk("s5", 32'h0000_0214, 32'hA000_0085, 16'd12);
        chk("sticky_misalign", {31'b0, misalign_err}, 32'd1);

        // Aligned JR to 0x100, then backward branch: 0x104 - 16 = 0xF4
        accept("jr2", 1'b1, 2'd0, 32'h0000_0100, 26'h0, 10'h040);
        hold_chk("jr2", 32'h0000_0100, 32'hA000_0040, 16'd13);
        accept("brb", 1'b1, 2'd2, 32'h0, 26'h3FF_FFFC, 10'h03D);
        hold_chk("brb", 32'h0000_00F4, 32'hA000_003D, 16'd14);

        // Stall with a redirect presented that must be ignored
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_sel   = 2'd1;
        redirect_imm   = 26'h000_0300;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            hold_chk("stall", 32'h0000_00F4, 32'hA000_003D, 16'd14);
        end
        accept("unstall", 1'b0, 2'd1, 32'h0, 26'h000_0300, 10'h03E);
        hold_chk("unstall", 32'h0000_00F8, 32'hA000_003E, 16'd15);
        chk("pre_rst_misalign", {31'b0, misalign_err}, 32'd1);

        // Reset mid-HOLD while stalled: takes effect without a clock edge
        instr_ready = 1'b0;
        reset       = 1'b0;
        #1;
        chk("arst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("arst_count",    {16'b0, instr_count}, 32'd0);
        chk("arst_pc",       instr_pc, 32'h0);
        chk("arst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("arst_addr",     {22'b0, imem_addr}, 32'd0);

        // Wrap: JR to 0xFFC, then sequential to 0x1000 fetching word 0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        hold_chk("r0", 32'h0000_0000, 32'hA000_0000, 16'd0);
        accept("tofc", 1'b1, 2'd0, 32'h0000_0FFC, 26'h0, 10'h3FF);
        hold_chk("tofc", 32'h0000_0FFC, 32'hA000_03FF, 16'd1);
        accept("wrap", 1'b0, 2'd0, 32'h0, 26'h0, 10'h000);
        hold_chk("wrap", 32'h0000_1000, 32'hA000_0000, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
